fifo_uart_tx: RTL and testbench

Downstream drain stage for the 8-bit `fifo_mem` buffer. It pops bytes from the FIFO whenever the FIFO is non-empty and transmission is enabled, then serializes each byte onto an asynchronous serial line: start bit, 8 data bits LSB first, optional even parity, one stop bit. It is the FIFO's only reader. It owns the FIFO `rd` strobe and never issues a read while `fifo_empty` is high.

---
 rtl/fifo_uart_tx.sv | 152 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// Drains the 8-bit fifo_mem buffer onto an asynchronous serial line.
// Frame format: start bit, 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
            $error("fifo_uart_tx: PARITY_EN must be 0 or 1");
        end
    endgenerate

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             parity_bit;
    logic             bit_end;
    logic             in_bit;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign in_bit  = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);

    // Byte datapath: loaded once per frame, parity taken from the whole captured byte.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            shift      <= fifo_data;
            parity_bit <= even_parity(fifo_data);
        end else if (state == DATA && bit_end) begin
            shift <= shift >> 1;
        end
    end

    always_ff @(posedge clk) begin
        tx_done <= 1'b0;
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            fifo_rd  <= 1'b0;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            if (in_bit) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        fifo_rd <= 1'b1;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end

                // The pop is already committed; enable or empty changes here are ignored.
                FETCH: begin
                    fifo_rd <= 1'b0;
                    state   <= LOAD;
                end

                LOAD: begin
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    state    <= START;
                end

                START: begin
                    if (bit_end) begin
                        tx    <= shift[0];
                        state <= DATA;
                    end
                end

                // shift[1] is the next bit because shift moves right on this same edge.
                DATA: begin
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            tx <= shift[1];
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    tx      <= 1'b1;
                    fifo_rd <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: an 8N1 and an 8E1 instance, each fed by a small FIFO model.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] en = 2'b00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // FIFO models, index 0 feeds the 8N1 instance, index 1 the 8E1 instance.
    logic [7:0]      mem [2][16];
    logic [1:0][4:0] fcnt = '0;
    logic [1:0][3:0] wp = '0;
    logic [1:0][3:0] rp = '0;
    logic [1:0][7:0] fdata = '0;
    logic [1:0]      uf = '0;
    logic [1:0]      push = '0;
    logic [1:0][7:0] pdata = '0;
    logic [1:0]      fempty;
    int              rd_cnt [2] = '{0, 0};
    logic [1:0]      rd_prev = '0;
    logic [1:0]      rd_wide = '0;

    logic rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;
    logic [1:0] rd_l, tx_l, busy_l, done_l;
    assign rd_l   = {rd1, rd0};
    assign tx_l   = {tx1, tx0};
    assign busy_l = {busy1, busy0};
    assign done_l = {done1, done0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            assign fempty[g] = (fcnt[g] == 5'd0);
            always @(posedge clk) begin
                if (push[g] && fcnt[g] != 5'd16) begin
                    mem[g][wp[g]] <= pdata[g];
                    wp[g] <= wp[g] + 4'd1;
                end
                if (rd_l[g]) begin
                    rd_cnt[g] <= rd_cnt[g] + 1;
                    if (fempty[g]) begin
                        uf[g] <= 1'b1;
                    end else begin
                        fdata[g] <= mem[g][rp[g]];
                        rp[g] <= rp[g] + 4'd1;
                    end
                end
                if (rd_l[g] && rd_prev[g]) rd_wide[g] <= 1'b1;
                rd_prev[g] <= rd_l[g];
                fcnt[g] <= fcnt[g] + ((push[g] && fcnt[g] != 5'd16) ? 5'd1 : 5'd0)
                                   - ((rd_l[g] && !fempty[g]) ? 5'd1 : 5'd0);
            end
        end
    endgenerate

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .fifo_empty(fempty[0]),
        .fifo_data(fdata[0]), .fifo_rd(rd0), .tx(tx0), .busy(busy0), .tx_done(done0)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .fifo_empty(fempty[1]),
        .fifo_data(fdata[1]), .fifo_rd(rd1), .tx(tx1), .busy(busy1), .tx_done(done1)
    );

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_byte(input int k, input logic [7:0] d);
        push[k]  = 1'b1;
        pdata[k] = d;
        @(negedge clk);
        push[k]  = 1'b0;
    endtask

    task automatic wait_rd(input int k, output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (rd_l[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
    endtask

    // Decodes one frame by sampling mid-bit; ok drops on timeout or bad start/stop.
    task automatic recv_frame(input int k, output logic [7:0] b, output logic p,
                              output int len, output int fall, output bit ok);
        int n;
        ok = 1'b1; b = '0; p = 1'b0; len = 0; fall = 0; n = 0;
        @(negedge clk);
        while (tx_l[k] !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (tx_l[k] !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        fall = cyc;
        repeat (2) @(negedge clk);
        if (tx_l[k] !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (4) @(negedge clk);
            b[i] = tx_l[k];
        end
        if (k == 1) begin
            repeat (4) @(negedge clk);
            p = tx_l[k];
        end
        repeat (4) @(negedge clk);
        if (tx_l[k] !== 1'b1) ok = 1'b0;
        n = 0;
        while (done_l[k] !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (done_l[k] !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        len = cyc - fall;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 2'b00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++; if (tx_l[k] !== 1'b1) begin errors++; $display("FAIL reset_tx[%0d] got %b want 1", k, tx_l[k]); end
            checks++; if (rd_l[k] !== 1'b0) begin errors++; $display("FAIL reset_rd[%0d] got %b want 0", k, rd_l[k]); end
            checks++; if (busy_l[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", k, busy_l[k]); end
            checks++; if (done_l[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d] got %b want 0", k, done_l[k]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        en = 2'b11;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({rd_l, tx_l, busy_l} !== 6'b00_11_00) begin
                errors++;
                $display("FAIL empty_idle cyc %0d rd=%b tx=%b busy=%b want rd=00 tx=11 busy=00",
                         i, rd_l, tx_l, busy_l);
            end
        end
        en = 2'b00;
    endtask

    task automatic test_single();
        logic [7:0] b; logic p; int len, fall, t_rd, base; bit ok;
        push_byte(0, 8'h55);
        base = rd_cnt[0];
        en[0] = 1'b1;
        wait_rd(0, t_rd);
        checks++; if (rd_l[0] !== 1'b1) begin errors++; $display("FAIL single_rd got %b want 1", rd_l[0]); end
        checks++; if (busy_l[0] !== 1'b1) begin errors++; $display("FAIL single_busy_rise got %b want 1", busy_l[0]); end
        recv_frame(0, b, p, len, fall, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_frame got ok=%b want 1", ok); end
        checks++; if (b !== 8'h55) begin errors++; $display("FAIL single_byte got %h want 55", b); end
        checks++; if (len != 40) begin errors++; $display("FAIL single_len got %0d want 40", len); end
        checks++; if (fall - t_rd != 2) begin errors++; $display("FAIL single_latency got %0d want 2", fall - t_rd); end
        checks++; if (busy_l[0] !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", busy_l[0]); end
        checks++; if (rd_cnt[0] - base != 1) begin errors++; $display("FAIL single_rd_count got %0d want 1", rd_cnt[0] - base); end
        @(negedge clk);
        checks++; if (done_l[0] !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b want 0", done_l[0]); end
        checks++; if (rd_wide[0] !== 1'b0) begin errors++; $display("FAIL single_rd_width got %b want 0", rd_wide[0]); end
    endtask

    task automatic test_parity();
        logic [7:0] b; logic p; int len, fall, prev; bit ok;
        logic [7:0] exp_b [2];
        logic       exp_p [2];
        exp_b = '{8'h01, 8'h55};
        exp_p = '{1'b1, 1'b0};
        push_byte(1, 8'h01);
        push_byte(1, 8'h55);
        en[1] = 1'b1;
        prev = 0;
        for (int i = 0; i < 2; i++) begin
            recv_frame(1, b, p, len, fall, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL parity_frame%0d got ok=%b want 1", i, ok); end
            checks++; if (b !== exp_b[i]) begin errors++; $display("FAIL parity_byte%0d got %h want %h", i, b, exp_b[i]); end
            checks++; if (p !== exp_p[i]) begin errors++; $display("FAIL parity_bit%0d got %b want %b", i, p, exp_p[i]); end
            checks++; if (len != 44) begin errors++; $display("FAIL parity_len%0d got %0d want 44", i, len); end
            if (i == 1) begin
                checks++; if (fall - prev != 47) begin errors++; $display("FAIL parity_period got %0d want 47", fall - prev); end
            end
            prev = fall;
        end
        en[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b; logic p; int len, fall, prev, base; bit ok;
        en[0] = 1'b0;
        for (int i = 1; i <= 16; i++) push_byte(0, 8'(i));
        checks++; if (fcnt[0] !== 5'd16) begin errors++; $display("FAIL burst_fill got %0d want 16", fcnt[0]); end
        base = rd_cnt[0];
        en[0] = 1'b1;
        prev = 0;
        for (int i = 1; i <= 16; i++) begin
            recv_frame(0, b, p, len, fall, ok);
            checks++;
            if (ok !== 1'b1 || b !== 8'(i)) begin
                errors++;
                $display("FAIL burst_byte%0d got %h ok=%b want %h ok=1", i, b, ok, 8'(i));
            end
            if (i > 1) begin
                checks++; if (fall - prev != 43) begin errors++; $display("FAIL burst_period%0d got %0d want 43", i, fall - prev); end
            end
            prev = fall;
        end
        repeat (20) @(negedge clk);
        checks++; if (rd_cnt[0] - base != 16) begin errors++; $display("FAIL burst_rd_count got %0d want 16", rd_cnt[0] - base); end
        checks++; if (uf[0] !== 1'b0) begin errors++; $display("FAIL burst_underflow got %b want 0", uf[0]); end
        checks++; if (busy_l[0] !== 1'b0) begin errors++; $display("FAIL burst_busy got %b want 0", busy_l[0]); end
        checks++; if (rd_wide[0] !== 1'b0) begin errors++; $display("FAIL burst_rd_width got %b want 0", rd_wide[0]); end
        checks++; if (fempty[0] !== 1'b1) begin errors++; $display("FAIL burst_empty got %b want 1", fempty[0]); end
    endtask

    task automatic test_enable_gating();
        logic [7:0] b; logic p; int len, fall, base, t_rd; bit ok;
        logic [7:0] exp_b [2];
        exp_b = '{8'h3C, 8'hF0};
        en[0] = 1'b0;
        push_byte(0, 8'hA3);
        push_byte(0, 8'h3C);
        push_byte(0, 8'hF0);
        base = rd_cnt[0];
        en[0] = 1'b1;
        wait_rd(0, t_rd);
        fork
            recv_frame(0, b, p, len, fall, ok);
            begin
                repeat (15) @(negedge clk);
                en[0] = 1'b0;
            end
        join
        checks++; if (ok !== 1'b1 || b !== 8'hA3) begin errors++; $display("FAIL gate_byte got %h ok=%b want a3 ok=1", b, ok); end
        checks++; if (len != 40) begin errors++; $display("FAIL gate_len got %0d want 40", len); end
        repeat (60) @(negedge clk);
        checks++; if (rd_cnt[0] - base != 1) begin errors++; $display("FAIL gate_rd_count got %0d want 1", rd_cnt[0] - base); end
        checks++; if (busy_l[0] !== 1'b0) begin errors++; $display("FAIL gate_busy got %b want 0", busy_l[0]); end
        checks++; if (tx_l[0] !== 1'b1) begin errors++; $display("FAIL gate_tx_idle got %b want 1", tx_l[0]); end
        checks++; if (fcnt[0] !== 5'd2) begin errors++; $display("FAIL gate_fifo_level got %0d want 2", fcnt[0]); end
        en[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            recv_frame(0, b, p, len, fall, ok);
            checks++; if (ok !== 1'b1 || b !== exp_b[i]) begin errors++; $display("FAIL gate_resume%0d got %h ok=%b want %h ok=1", i, b, ok, exp_b[i]); end
        end
        repeat (10) @(negedge clk);
        checks++; if (rd_cnt[0] - base != 3) begin errors++; $display("FAIL gate_rd_total got %0d want 3", rd_cnt[0] - base); end
        checks++; if (fempty[0] !== 1'b1) begin errors++; $display("FAIL gate_empty got %b want 1", fempty[0]); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b; logic p; int len, fall, t_rd; bit ok;
        en[0] = 1'b0;
        push_byte(0, 8'h81);
        push_byte(0, 8'h7E);
        en[0] = 1'b1;
        wait_rd(0, t_rd);
        repeat (12) @(negedge clk);
        checks++; if (tx_l[0] !== 1'b0 || busy_l[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre got tx=%b busy=%b want tx=0 busy=1", tx_l[0], busy_l[0]); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (tx_l[0] !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", tx_l[0]); end
        checks++; if (busy_l[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_l[0]); end
        checks++; if (rd_l[0] !== 1'b0) begin errors++; $display("FAIL midrst_rd got %b want 0", rd_l[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        recv_frame(0, b, p, len, fall, ok);
        checks++; if (ok !== 1'b1 || b !== 8'h7E) begin errors++; $display("FAIL midrst_next got %h ok=%b want 7e ok=1", b, ok); end
        checks++; if (len != 40) begin errors++; $display("FAIL midrst_len got %0d want 40", len); end
        repeat (5) @(negedge clk);
        checks++; if (fempty[0] !== 1'b1 || uf[0] !== 1'b0) begin errors++; $display("FAIL midrst_fifo got empty=%b uf=%b want empty=1 uf=0", fempty[0], uf[0]); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_parity();
        test_back_to_back();
        test_enable_gating();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
